// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter one frame at a time.
// Launches a one-cycle start pulse per byte and waits for frame completion.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          tx_en,
  input  logic          ovf_clr,
  input  logic          uart_tx_busy,
  input  logic          uart_tx_done,
  output logic          uart_start,
  output logic [7:0]    uart_tx_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          active
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_en && !full;
  assign active = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    uart_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_en && !empty && !uart_tx_busy) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        uart_start = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (uart_tx_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      uart_tx_data <= 8'h00;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop) begin
        rptr         <= rptr + AW'(1);
        uart_tx_data <= mem[rptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A rejected push takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (wr_en && full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple UART responder.
// Expected bytes are queued at push time and checked at each start pulse.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        tx_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        uart_tx_busy = 1'b0;
  logic        uart_tx_done = 1'b0;
  logic        uart_start;
  logic [7:0]  uart_tx_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        active;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_start = 0;
  bit prev_v = 0;
  bit auto_uart = 1;
  logic [7:0] sb_q[$];

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .tx_en        (tx_en),
    .ovf_clr      (ovf_clr),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_done (uart_tx_done),
    .uart_start   (uart_start),
    .uart_tx_data (uart_tx_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .active       (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, req, req);
    end
  endtask

  // UART responder: frame completes 10 cycles after the start pulse.
  always begin
    @(negedge clk);
    if (uart_start && auto_uart) begin
      uart_tx_busy = 1'b1;
      repeat (10) @(negedge clk);
      uart_tx_done = 1'b1;
      @(negedge clk);
      uart_tx_done = 1'b0;
      uart_tx_busy = 1'b0;
    end
  end

  // Monitor: every start pulse must carry the next expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 0;
    end else if (uart_start) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_start: data 0x%0h with no byte queued",
                 uart_tx_data);
      end else begin
        check("start_data", int'(uart_tx_data), int'(sb_q.pop_front()));
      end
      if (prev_v)
        check("start_gap_ok", int'((cyc - last_start) >= 12), 1);
      prev_v = 1;
      last_start = cyc;
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_tx);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_tx) sb_q.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok;
    ok = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (empty && !active && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_start", int'(uart_start), 0);
    check("rst_data", int'(uart_tx_data), 0);
    check("rst_active", int'(active), 0);
    reset = 1'b1;

    // Single byte and latency
    tx_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hA5;
    sb_q.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat_count1", int'(count), 1);
    check("lat_nostart", int'(uart_start), 0);
    @(negedge clk);
    check("lat_start", int'(uart_start), 1);
    check("lat_data", int'(uart_tx_data), 8'hA5);
    check("lat_count0", int'(count), 0);
    @(negedge clk);
    check("lat_onepulse", int'(uart_start), 0);
    check("lat_active", int'(active), 1);
    wait_idle("single_drain", 100);
    check("single_empty", int'(empty), 1);

    // Fill to full, then overflow
    tx_en = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push_byte(8'(8'h10 + i), 1);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);
    check("fill_ovf0", int'(overflow), 0);
    push_byte(8'hEE, 0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 16);
    pulse_clr();
    check("ovf_clr", int'(overflow), 0);
    tx_en = 1'b1;
    wait_idle("fill_drain", 600);

    // Push rejected while a pop happens at full
    tx_en = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push_byte(8'(8'h40 + i), 1);
    @(negedge clk);
    tx_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hBB;
    @(negedge clk);
    wr_en = 1'b0;
    check("sim_count", int'(count), 15);
    check("sim_ovf", int'(overflow), 1);
    check("sim_notfull", int'(full), 0);
    push_byte(8'hCC, 1);
    check("sim_refull", int'(full), 1);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hDD;
    ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    check("set_wins", int'(overflow), 1);
    check("set_wins_cnt", int'(count), 16);
    pulse_clr();
    check("clr_after", int'(overflow), 0);
    wait_idle("sim_drain", 800);

    // Ordered burst
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 8'(i);
      sb_q.push_back(8'(i));
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("order_drain", 200);

    // Interleaved traffic across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 200 && full; k++) @(negedge clk);
      push_byte(8'(i * 37 + 5), 1);
      repeat ((i % 5) * 3) @(negedge clk);
    end
    wait_idle("wrap_drain", 1200);

    // Reset in the middle of a frame
    auto_uart = 0;
    push_byte(8'h77, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      push_byte(8'(8'hC0 + i), 0);
    check("mid_active", int'(active), 1);
    check("mid_count", int'(count), 3);
    #2 reset = 1'b0;
    #1;
    check("mr_count", int'(count), 0);
    check("mr_empty", int'(empty), 1);
    check("mr_full", int'(full), 0);
    check("mr_ovf", int'(overflow), 0);
    check("mr_start", int'(uart_start), 0);
    check("mr_data", int'(uart_tx_data), 0);
    check("mr_active", int'(active), 0);
    @(negedge clk);
    reset = 1'b1;
    auto_uart = 1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", int'(active), 0);
    check("post_rst_sb", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; must be a power of two, minimum 2.
REQ-002 SHALL have parameter AW, default 4, meaning pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1 bit: push request from bus side.
REQ-006 SHALL have port wr_data, input, 8 bits: byte to push.
REQ-007 SHALL have port tx_en, input, 1 bit: drain enable.
REQ-008 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-009 SHALL have port uart_tx_busy, input, 1 bit: UART transmitter busy.
REQ-010 SHALL have port uart_tx_done, input, 1 bit: one-cycle frame-complete pulse from the UART transmitter.
REQ-011 SHALL have port uart_start, output, 1 bit: one-cycle launch pulse to the UART transmitter.
REQ-012 SHALL have port uart_tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-013 SHALL have port full, output, 1 bit: FIFO full flag.
REQ-014 SHALL have port empty, output, 1 bit: FIFO empty flag.
REQ-015 SHALL have port count, output, AW+1 bits: current FIFO occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set by a rejected push.
REQ-017 SHALL have port active, output, 1 bit: high whenever the state machine is not IDLE.

Function
REQ-018 SHALL implement a circular FIFO with AW-bit read/write pointers wrapping DEPTH-1 -> 0, and a registered count.
REQ-019 SHALL derive full = (count == DEPTH) and empty = (count == 0), both from registered count.
REQ-020 SHALL accept a push when wr_en=1 and full=0, writing wr_data at wptr and incrementing wptr.
REQ-021 SHALL reject a push when wr_en=1 and full=1, even if a pop occurs in the same cycle, and SHALL set overflow=1 on the next edge.
REQ-022 SHALL update count as count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-023 SHALL implement a state machine with states IDLE, LAUNCH and WAIT_DONE.
REQ-024 IDLE: when tx_en=1, empty=0 and uart_tx_busy=0, SHALL pop the head byte into the uart_tx_data register, advance rptr, and go to LAUNCH.
REQ-025 LAUNCH: SHALL drive uart_start=1 for exactly this one cycle, then go to WAIT_DONE.
REQ-026 WAIT_DONE: SHALL return to IDLE on the cycle after uart_tx_done=1; any other input SHALL keep it in WAIT_DONE.
REQ-027 SHALL hold uart_tx_data stable from LAUNCH until the next pop.
REQ-028 SHALL ignore a deassertion of tx_en outside IDLE; the byte in flight completes.
REQ-029 SHALL NOT generate data writes from uart_tx_done in IDLE or LAUNCH; such a pulse is ignored.
REQ-030 Latency: with the FIFO empty and the core idle, a push at edge N SHALL produce count=1 at N+1, the pop at N+1, and uart_start=1 during cycle N+1..N+2.
REQ-031 Back-to-back: the next pop SHALL occur no earlier than the first IDLE cycle after uart_tx_done.
REQ-032 ovf_clr=1 SHALL clear overflow; if ovf_clr and a rejected push coincide, overflow SHALL remain 1 (set wins).
REQ-033 SHALL provide no read-while-empty path; the state machine never pops when empty=1.

Reset
REQ-034 reset=0 SHALL asynchronously force state=IDLE, wptr=rptr=0, count=0, empty=1, full=0, overflow=0, uart_start=0, uart_tx_data=8'h00, active=0.
REQ-035 Reset asserted mid-frame SHALL discard all FIFO contents and the pending wait, with no uart_start after release until a new push.
REQ-036 FIFO storage contents SHALL NOT require reset.

Verification
REQ-037 Single byte: push 8'hA5 with tx_en=1 and the core idle -> one uart_start pulse two cycles later, uart_tx_data=8'hA5; after a tx_done pulse, active=0 and empty=1.
REQ-038 Fill: 16 pushes with tx_en=0 -> full=1, count=16; a 17th push -> overflow=1, count=16, and the 17th byte is never transmitted.
REQ-039 Order: push 8'h01..8'h05 with tx_en=1 and tx_done modelled 10 cycles after each start -> five starts carrying 01..05 in order, each spaced by its tx_done.
REQ-040 Wrap: push/drain 40 bytes interleaved -> pointers wrap and the data sequence is intact.
REQ-041 Simultaneous: at full, push and pop in the same cycle -> push rejected, overflow=1, count=15; ovf_clr together with a rejected push -> overflow stays 1.
REQ-042 Reset mid-frame: in WAIT_DONE with 3 bytes queued, pulse reset=0 -> all outputs at reset values, and no start after release.
